// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger: FSM encoding, word widths,
// out-of-range code and the double-dabble digit adjust step.
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    CONVERT
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int DIST_W      = 24;
  localparam int BCD_W       = 20;
  localparam int HCM_W       = 16;

  localparam logic [DIST_W-1:0] OOR_CODE = 24'h999999;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / BCD_DIGIT_W; i++) begin
      if (b[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = b[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one shift-add per clk.
// start is sampled only when idle; done pulses one cycle, 17 clk after the load edge.
module bin2bcd_seq
  import ranger_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [HCM_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic             busy_q, busy_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [HCM_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             done_q, done_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = '0;
        bin_d  = bin;
        bcd_d  = '0;
      end
    end else if (cnt_q == 5'(HCM_W)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else begin
      {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
      cnt_d          = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 driver: periodic trigger, echo width in 0.01 cm, BCD result with data_vld strobe.
// ULTRASONIC_RANGER_OOR_REPORT_EN: timeouts report 24'h999999 with data_vld instead of staying silent.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned PERIOD_CYCLES  = 3_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
  parameter int unsigned HCM_DIV        = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              echo,
  output logic              trig,
  output logic              data_vld,
  output logic [DIST_W-1:0] distance_data
);

  state_e            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic [31:0]       period_q, period_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       div_q, div_d;
  logic [HCM_W-1:0]  hcm_q, hcm_d;
  logic              start_q, start_d;
  logic              trig_q, trig_d;
  logic              vld_q, vld_d;
  logic [DIST_W-1:0] dist_q, dist_d;

  logic              echo_s, echo_rise, echo_fall;
  logic              count_en, timeout;
  logic              bcd_done;
  logic [BCD_W-1:0]  bcd;

  // sync_q[1] is the synchronized echo, sync_q[2] its previous value for edge detect.
  assign echo_s    = sync_q[1];
  assign echo_rise = sync_q[1] & ~sync_q[2];
  assign echo_fall = ~sync_q[1] & sync_q[2];

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_q),
    .bin   (hcm_q),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[1:0], echo};
    period_d = (period_q == '1) ? period_q : period_q + 32'd1;
    cnt_d    = cnt_q;
    div_d    = div_q;
    hcm_d    = hcm_q;
    start_d  = 1'b0;
    vld_d    = 1'b0;
    dist_d   = dist_q;
    count_en = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && period_q >= PERIOD_CYCLES - 1) state_d = TRIG;
      end
      TRIG: begin
        cnt_d = cnt_q + 32'd1;
        div_d = '0;
        hcm_d = '0;
        if (cnt_q == TRIG_CYCLES - 1) state_d = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        cnt_d = cnt_q + 32'd1;
        // The rise cycle is the first echo-high cycle, so it is counted too.
        if (echo_rise) begin
          state_d  = MEASURE;
          count_en = 1'b1;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          timeout = 1'b1;
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + 32'd1;
        if (echo_fall) begin
          state_d = CONVERT;
          start_d = 1'b1;
        end else if (echo_s) begin
          count_en = 1'b1;
          if (cnt_q == TIMEOUT_CYCLES - 1) timeout = 1'b1;
        end
      end
      CONVERT: begin
        if (bcd_done) begin
          vld_d   = 1'b1;
          dist_d  = {{(DIST_W-BCD_W){1'b0}}, bcd};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (count_en) begin
      if (div_q == HCM_DIV - 1) begin
        div_d = '0;
        if (hcm_q != '1) hcm_d = hcm_q + 16'd1;
      end else begin
        div_d = div_q + 32'd1;
      end
    end

    if (timeout) begin
      state_d = IDLE;
`ifdef ULTRASONIC_RANGER_OOR_REPORT_EN
      vld_d  = 1'b1;
      dist_d = OOR_CODE;
`endif
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == TRIG && state_q != TRIG) period_d = '0;
    trig_d = (state_d == TRIG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      hcm_q    <= '0;
      start_q  <= 1'b0;
      trig_q   <= 1'b0;
      vld_q    <= 1'b0;
      dist_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      hcm_q    <= hcm_d;
      start_q  <= start_d;
      trig_q   <= trig_d;
      vld_q    <= vld_d;
      dist_q   <= dist_d;
    end
  end

  assign trig          = trig_q;
  assign data_vld      = vld_q;
  assign distance_data = dist_q;

endmodule
